// File: rtl/disp_fifo_arbiter.sv
// Read-side scheduler for the two dispatcher output FIFOs: urgency-first, otherwise
// round-robin in bounded bursts, feeding a single registered valid/ready output stage.
module disp_fifo_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  almost_full0,
  input  logic                  almost_full1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  pop0,
  output logic                  pop1,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sel,
  output logic                  busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             last, last_nxt;

  logic             adv;
  logic             urg0, urg1;
  logic             serving, cur;
  logic             cur_empty, cur_af, other_urg;
  logic             pop, burst_end, rearb;
  logic             pick_prev, pick_go, pick_lane;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  sel_p1;

  // Returns {go, lane}: lone urgent lane first, then the lane that was not served last.
  function automatic logic [1:0] pick(input logic prev, input logic e0, input logic e1,
                                      input logic u0, input logic u1);
    logic [1:0] res;
    if (u0 ^ u1)
      res = {1'b1, u1};
    else if (!e0 && !e1)
      res = {1'b1, ~prev};
    else if (!e0)
      res = 2'b10;
    else if (!e1)
      res = 2'b11;
    else
      res = 2'b00;
    return res;
  endfunction

  assign adv       = ~vld_p1 | out_ready;
  assign urg0      = almost_full0 & ~empty0;
  assign urg1      = almost_full1 & ~empty1;

  assign serving   = (state != IDLE);
  assign cur       = (state == SERVE1);
  assign cur_empty = cur ? empty1 : empty0;
  assign cur_af    = cur ? almost_full1 : almost_full0;
  assign other_urg = cur ? urg0 : urg1;

  assign pop       = reset & serving & adv & ~cur_empty;
  assign pop0      = pop & ~cur;
  assign pop1      = pop & cur;

  assign burst_end = pop & (burst_cnt == CNT_LAST);
  // Backpressure freezes the grant; otherwise any of burst end, drained lane or preemption
  // collapses into one re-arbitration.
  assign rearb     = serving & adv & (burst_end | cur_empty | (other_urg & ~cur_af));

  // The lane just served counts as "last" when re-arbitrating out of a burst.
  assign pick_prev = serving ? cur : last;
  assign {pick_go, pick_lane} = pick(pick_prev, empty0, empty1, urg0, urg1);

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_nxt      = last;
    if (!serving) begin
      if (pick_go) begin
        state_nxt     = pick_lane ? SERVE1 : SERVE0;
        burst_cnt_nxt = '0;
      end
    end else if (rearb) begin
      last_nxt      = cur;
      burst_cnt_nxt = '0;
      state_nxt     = pick_go ? (pick_lane ? SERVE1 : SERVE0) : IDLE;
    end else if (pop) begin
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last      <= last_nxt;
    end
  end

  // Stage p1: output register, loaded on a pop, drained when the consumer takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= 1'b0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      data_p1 <= cur ? data1 : data0;
      sel_p1  <= cur;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign busy      = serving;

endmodule
